fft_twiddle_sched: RTL and testbench

FFT_TWIDDLE_SCHED -- requirements
Module: fft_twiddle_sched

---
 rtl/fft_twiddle_sched_if.sv | 26 ++
 rtl/fft_twiddle_sched.sv | 127 ++++++++++++
 tb/tb_fft_twiddle_sched.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fft_twiddle_sched_if.sv
// Schedule handshake bundle between the FFT datapath (master) and the
// twiddle address scheduler (slave).
interface fft_twiddle_sched_if #(
    parameter int LOGN = 5,
    parameter int SW   = 3
) ();
    logic            start;
    logic            stall;
    logic [LOGN-2:0] coeff_addr;
    logic            addr_valid;
    logic [SW-1:0]   stage;
    logic [LOGN-2:0] bfly_idx;
    logic            stage_last;
    logic            busy;
    logic            done;

    modport master (
        output start, stall,
        input  coeff_addr, addr_valid, stage, bfly_idx, stage_last, busy, done
    );

    modport slave (
        input  start, stall,
        output coeff_addr, addr_valid, stage, bfly_idx, stage_last, busy, done
    );
endinterface

// File: rtl/fft_twiddle_sched.sv
// Radix-2 DIF twiddle ROM address scheduler: walks LOGN stages of N/2
// butterflies, one address per unstalled cycle, then pulses done.
module fft_twiddle_sched #(
    parameter int N    = 32,
    parameter int LOGN = 5,
    parameter int SW   = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    fft_twiddle_sched_if.slave   bus
);
    generate
        if (N != (1 << LOGN) || LOGN < 2 || LOGN > 10) begin : g_bad_n
            $error("fft_twiddle_sched: N must be 2**LOGN with 4 <= N <= 1024");
        end
        if ((1 << SW) < LOGN) begin : g_bad_sw
            $error("fft_twiddle_sched: SW too narrow for LOGN stages");
        end
    endgenerate

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    localparam logic [LOGN-2:0] BFLY_LAST  = (LOGN-1)'(N/2 - 1);
    localparam logic [SW-1:0]   STAGE_LAST = SW'(LOGN - 1);

    state_t          r_state;
    logic [SW-1:0]   r_stage;     // stage of the next address to emit
    logic [LOGN-2:0] r_bfly;      // butterfly of the next address to emit
    logic            r_fin;       // every address of the frame has been emitted
    logic [LOGN-2:0] r_addr;
    logic            r_vld;
    logic [SW-1:0]   r_stage_o;
    logic [LOGN-2:0] r_bfly_o;
    logic            r_slast;
    logic            r_busy;
    logic            r_done;

    logic [LOGN-2:0] w_addr;
    logic            w_bfly_end;

    // (bfly mod 2^(LOGN-1-stage)) << stage == bfly << stage truncated to LOGN-1 bits
    assign w_addr     = r_bfly << r_stage;
    assign w_bfly_end = (r_bfly == BFLY_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_stage   <= '0;
            r_bfly    <= '0;
            r_fin     <= 1'b0;
            r_addr    <= '0;
            r_vld     <= 1'b0;
            r_stage_o <= '0;
            r_bfly_o  <= '0;
            r_slast   <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    r_done  <= 1'b0;
                    r_vld   <= 1'b0;
                    r_slast <= 1'b0;
                    if (bus.start) begin
                        r_state <= S_RUN;
                        r_busy  <= 1'b1;
                        r_stage <= '0;
                        r_fin   <= 1'b0;
                        // First address goes out immediately unless the datapath is stalled.
                        if (!bus.stall) begin
                            r_vld     <= 1'b1;
                            r_addr    <= '0;
                            r_stage_o <= '0;
                            r_bfly_o  <= '0;
                            r_bfly    <= (LOGN-1)'(1);
                        end else begin
                            r_bfly    <= '0;
                        end
                    end else begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (r_fin) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_vld   <= 1'b0;
                        r_slast <= 1'b0;
                    end else if (bus.stall) begin
                        r_vld   <= 1'b0;
                        r_slast <= 1'b0;
                    end else begin
                        r_vld     <= 1'b1;
                        r_addr    <= w_addr;
                        r_stage_o <= r_stage;
                        r_bfly_o  <= r_bfly;
                        r_slast   <= w_bfly_end;
                        if (w_bfly_end) begin
                            r_bfly <= '0;
                            if (r_stage == STAGE_LAST) r_fin <= 1'b1;
                            else                       r_stage <= r_stage + 1'b1;
                        end else begin
                            r_bfly <= r_bfly + 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_vld   <= 1'b0;
                    r_done  <= 1'b0;
                    r_slast <= 1'b0;
                end
            endcase
        end
    end

    assign bus.coeff_addr = r_addr;
    assign bus.addr_valid = r_vld;
    assign bus.stage      = r_stage_o;
    assign bus.bfly_idx   = r_bfly_o;
    assign bus.stage_last = r_slast;
    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
endmodule

// File: tb/tb_fft_twiddle_sched.sv
// Scoreboard bench for fft_twiddle_sched (N=32): stimulus queues expected
// addresses, a negedge monitor pops and compares each valid output.
module tb_fft_twiddle_sched;
    localparam int N    = 32;
    localparam int LOGN = 5;
    localparam int SW   = 3;

    typedef struct packed {
        logic [SW-1:0]   stg;
        logic [LOGN-2:0] bf;
        logic [LOGN-2:0] ad;
        logic            sl;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fft_twiddle_sched_if #(.LOGN(LOGN), .SW(SW)) bus ();
    fft_twiddle_sched #(.N(N), .LOGN(LOGN), .SW(SW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   vcount   = 0;
    int   slcnt    = 0;
    exp_t sbq[$];
    exp_t me;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Expected address: (bfly mod (N >> (stage+1))) << stage
    task automatic push_frame(input int cnt);
        exp_t x;
        int   k;
        k = 0;
        for (int s = 0; s < LOGN; s++) begin
            for (int b = 0; b < N/2; b++) begin
                if (k < cnt) begin
                    x.stg = SW'(s);
                    x.bf  = (LOGN-1)'(b);
                    x.ad  = (LOGN-1)'((b % (N >> (s + 1))) << s);
                    x.sl  = (b == N/2 - 1);
                    sbq.push_back(x);
                    k++;
                end
            end
        end
    endtask

    always @(negedge clk) begin
        if (bus.addr_valid === 1'b1) begin
            vcount++;
            if (bus.stage_last) slcnt++;
            if (sbq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_addr: got stage=%0d bfly=%0d addr=%0d expected no valid output",
                         bus.stage, bus.bfly_idx, bus.coeff_addr);
            end else begin
                me = sbq.pop_front();
                chk("sb_stage", int'(bus.stage), int'(me.stg));
                chk("sb_bfly", int'(bus.bfly_idx), int'(me.bf));
                chk("sb_addr", int'(bus.coeff_addr), int'(me.ad));
                chk("sb_stage_last", int'(bus.stage_last), int'(me.sl));
            end
        end
    end

    task automatic wait_done(input string name, output int dc);
        bit found;
        found = 0;
        dc = -1;
        for (int i = 0; i < 400 && !found; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                found = 1;
                dc = cyc;
            end
        end
        chk({name, "_done_seen"}, int'(found), 1);
        if (found) begin
            chk({name, "_busy_at_done"}, int'(bus.busy), 0);
            chk({name, "_valid_at_done"}, int'(bus.addr_valid), 0);
        end
    endtask

    task automatic wait_pos(input int s, input int b);
        bit found;
        found = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            if (bus.addr_valid === 1'b1 && int'(bus.stage) == s && int'(bus.bfly_idx) == b)
                found = 1;
        end
        chk("reach_position", int'(found), 1);
    endtask

    int t0, dc, dc2;

    initial begin
        rst = 1'b1;
        bus.start = 1'b0;
        bus.stall = 1'b0;
        repeat (2) @(negedge clk);

        chk("rst_addr", int'(bus.coeff_addr), 0);
        chk("rst_valid", int'(bus.addr_valid), 0);
        chk("rst_stage", int'(bus.stage), 0);
        chk("rst_bfly", int'(bus.bfly_idx), 0);
        chk("rst_stage_last", int'(bus.stage_last), 0);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_done", int'(bus.done), 0);

        // Plain frame; start accepted right after reset; a start pulse mid-RUN is ignored
        push_frame(80);
        vcount = 0; slcnt = 0;
        t0 = cyc;
        rst = 1'b0;
        bus.start = 1'b1;
        @(negedge clk);
        chk("first_valid", int'(bus.addr_valid), 1);
        chk("first_busy", int'(bus.busy), 1);
        bus.start = 1'b0;
        repeat (20) @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done("plain", dc);
        chk("plain_done_latency", dc - t0, 81);
        chk("plain_valid_count", vcount, 80);
        chk("plain_stage_last_count", slcnt, 5);
        @(negedge clk);
        chk("done_one_cycle", int'(bus.done), 0);
        chk("idle_busy", int'(bus.busy), 0);

        // Three-cycle stall at stage 2, bfly 5
        push_frame(80);
        vcount = 0;
        t0 = cyc;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_pos(2, 5);
        bus.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_invalid", int'(bus.addr_valid), 0);
            chk("stall_hold_bfly", int'(bus.bfly_idx), 5);
        end
        bus.stall = 1'b0;
        @(negedge clk);
        chk("resume_addr", int'(bus.coeff_addr), 8);
        wait_done("stall", dc);
        chk("stall_done_latency", dc - t0, 84);
        chk("stall_valid_count", vcount, 80);
        @(negedge clk);

        // start held high: back-to-back frames with one DONE gap
        push_frame(80);
        push_frame(80);
        vcount = 0;
        t0 = cyc;
        bus.start = 1'b1;
        wait_done("b2b1", dc);
        chk("b2b_first_done", dc - t0, 81);
        @(negedge clk);
        chk("b2b_restart_valid", int'(bus.addr_valid), 1);
        chk("b2b_restart_bfly", int'(bus.bfly_idx), 0);
        repeat (10) @(negedge clk);
        bus.start = 1'b0;
        wait_done("b2b2", dc2);
        chk("b2b_second_done", dc2 - dc, 81);
        chk("b2b_valid_count", vcount, 160);
        @(negedge clk);

        // Reset abort at stage 3, bfly 7, then a fresh frame
        push_frame(56);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_pos(3, 7);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_valid", int'(bus.addr_valid), 0);
        chk("abort_addr", int'(bus.coeff_addr), 0);
        chk("abort_stage", int'(bus.stage), 0);
        chk("abort_bfly", int'(bus.bfly_idx), 0);
        chk("abort_busy", int'(bus.busy), 0);
        chk("abort_done", int'(bus.done), 0);
        chk("abort_queue_drained", sbq.size(), 0);
        push_frame(80);
        vcount = 0;
        t0 = cyc;
        rst = 1'b0;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done("after_abort", dc);
        chk("after_abort_latency", dc - t0, 81);
        chk("after_abort_valid_count", vcount, 80);
        @(negedge clk);

        // start together with stall in IDLE; stall drops two cycles later
        push_frame(80);
        vcount = 0;
        t0 = cyc;
        bus.start = 1'b1;
        bus.stall = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        chk("ss_valid1", int'(bus.addr_valid), 0);
        chk("ss_busy1", int'(bus.busy), 1);
        @(negedge clk);
        chk("ss_valid2", int'(bus.addr_valid), 0);
        bus.stall = 1'b0;
        @(negedge clk);
        chk("ss_first_valid", int'(bus.addr_valid), 1);
        chk("ss_first_addr", int'(bus.coeff_addr), 0);
        wait_done("ss", dc);
        chk("ss_done_latency", dc - t0, 83);
        chk("ss_valid_count", vcount, 80);

        @(negedge clk);
        chk("final_queue_empty", sbq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
